// File: rtl/tlp_pkg.sv
// Shared framing constants and transmit-state encoding for the TLP byte lane.
package tlp_pkg;

    localparam logic [7:0] K_STP          = 8'hFB;
    localparam logic [7:0] K_END          = 8'hFD;
    localparam logic [7:0] IDLE_BYTE      = 8'h00;
    localparam int         TLP_BODY_BYTES = 18;
    localparam int         BODY_BITS      = TLP_BODY_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STP  = 3'd1,
        ST_BODY = 3'd2,
        ST_END  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick starting after the last winner,
// pointer advances only when the caller accepts the pick.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     accept,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] last;
    int               idx;

    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        valid  = 1'b0;
        winner = last;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    // Reset pointer at N_REQ-1 so requester 0 is searched first.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= IDX_W'(N_REQ - 1);
        end else if (accept && valid) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/tlp_tx_scheduler.sv
// Grants one requester at a time and frames its 18-byte body as STP/body/END
// on the shared byte lane. State names the symbol currently on the lane.
module tlp_tx_scheduler
    import tlp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*BODY_BITS-1:0] req_body,
    output logic [N_REQ-1:0]           grant,
    output logic [7:0]                 data_out,
    output logic                       datak_out,
    output logic                       busy,
    output logic [3:0]                 tx_count
);

    localparam int         IDX_W     = $clog2(N_REQ);
    localparam logic [4:0] LAST_BYTE = 5'(TLP_BODY_BYTES - 1);
    localparam logic [3:0] GAP_LAST  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    tx_state_t            state;
    logic [BODY_BITS-1:0] body_sr;
    logic [4:0]           byte_cnt;
    logic [3:0]           gap_cnt;

    logic [IDX_W-1:0]     winner;
    logic                 arb_valid;
    logic                 arb_window;
    logic                 arb_go;
    logic [N_REQ-1:0]     win_onehot;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (arb_go),
        .winner (winner),
        .valid  (arb_valid)
    );

    // Arbitration is allowed in IDLE, at END when there is no gap, and on the last gap cycle.
    always_comb begin
        arb_window = 1'b0;
        case (state)
            ST_IDLE: arb_window = 1'b1;
            ST_END:  arb_window = (GAP == 0);
            ST_GAP:  arb_window = (gap_cnt == GAP_LAST);
            default: arb_window = 1'b0;
        endcase
        arb_go             = en && arb_valid && arb_window;
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    // NOTE: the body shift register is pure datapath, always reloaded before use, so it has no reset.
    always_ff @(posedge clk) begin
        if (arb_go) begin
            body_sr <= req_body[int'(winner)*BODY_BITS +: BODY_BITS];
        end else if (state == ST_STP || state == ST_BODY) begin
            body_sr <= body_sr >> 8;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            data_out  <= IDLE_BYTE;
            datak_out <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_count  <= '0;
        end else begin
            grant <= '0;
            if (arb_go) begin
                state     <= ST_STP;
                data_out  <= K_STP;
                datak_out <= 1'b1;
                grant     <= win_onehot;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_STP: begin
                        state     <= ST_BODY;
                        byte_cnt  <= '0;
                        data_out  <= body_sr[7:0];
                        datak_out <= 1'b0;
                    end
                    ST_BODY: begin
                        if (byte_cnt == LAST_BYTE) begin
                            state     <= ST_END;
                            data_out  <= K_END;
                            datak_out <= 1'b1;
                            tx_count  <= tx_count + 4'd1;
                        end else begin
                            byte_cnt  <= byte_cnt + 5'd1;
                            data_out  <= body_sr[7:0];
                            datak_out <= 1'b0;
                        end
                    end
                    ST_END: begin
                        state     <= (GAP == 0) ? ST_IDLE : ST_GAP;
                        gap_cnt   <= '0;
                        data_out  <= IDLE_BYTE;
                        datak_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                    ST_GAP: begin
                        gap_cnt   <= gap_cnt + 4'd1;
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                        end
                        data_out  <= IDLE_BYTE;
                        datak_out <= 1'b0;
                    end
                    default: begin
                        state     <= ST_IDLE;
                        data_out  <= IDLE_BYTE;
                        datak_out <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Directed bench for tlp_tx_scheduler: framing, round-robin order, gap, enable, reset and wrap.
module tb_tlp_tx_scheduler;

    localparam int N_REQ = 4;
    localparam int BB    = 144;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [N_REQ-1:0] req;
    logic [BB-1:0]    body [N_REQ];
    logic [N_REQ*BB-1:0] req_body;

    logic [N_REQ-1:0] grant,    g_grant;
    logic [7:0]       data_out, g_data;
    logic             datak_out, g_datak;
    logic             busy,     g_busy;
    logic [3:0]       tx_count, g_count;

    int n_checks = 0;
    int n_bad    = 0;

    assign req_body = {body[3], body[2], body[1], body[0]};

    always #5 clk = ~clk;

    tlp_tx_scheduler #(.N_REQ(N_REQ), .GAP(0)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .req_body(req_body),
        .grant(grant), .data_out(data_out), .datak_out(datak_out),
        .busy(busy), .tx_count(tx_count)
    );

    tlp_tx_scheduler #(.N_REQ(N_REQ), .GAP(2)) dut_gap (
        .clk(clk), .reset(reset), .en(en), .req(req), .req_body(req_body),
        .grant(g_grant), .data_out(g_data), .datak_out(g_datak),
        .busy(g_busy), .tx_count(g_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        en    = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Called in the STP cycle; leaves the bench in the END cycle.
    task automatic expect_packet(input int who, input logic [BB-1:0] b, input bit drop);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[who] = 1'b1;
        check($sformatf("stp_data_r%0d", who), 32'(data_out), 32'hFB);
        check("stp_k", 32'(datak_out), 32'd1);
        check($sformatf("stp_grant_r%0d", who), 32'(grant), 32'(oh));
        check("stp_busy", 32'(busy), 32'd1);
        if (drop) req[who] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            check($sformatf("body_r%0d_b%0d", who, i), {23'd0, datak_out, data_out}, {24'd0, b[8*i +: 8]});
            check("body_grant", 32'(grant), 32'd0);
        end
        step();
        check("end_data", {23'd0, datak_out, data_out}, 32'h1FD);
        check("end_busy", 32'(busy), 32'd1);
    endtask

    int busy_cycles;

    initial begin
        for (int r = 0; r < N_REQ; r++)
            for (int k = 0; k < 18; k++)
                body[r][8*k +: 8] = 8'((r << 5) + k + 1);

        // Reset state
        do_reset();
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_k", 32'(datak_out), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(tx_count), 32'd0);

        // Single request, body 01..12
        req = 4'b0001;
        step();
        busy_cycles = 1;
        expect_packet(0, body[0], 1'b1);
        check("single_count", 32'(tx_count), 32'd1);
        busy_cycles += 19;
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy) busy_cycles++;
            check("single_idle", {23'd0, datak_out, data_out}, 32'h000);
        end
        check("single_busy_len", 32'(busy_cycles), 32'd20);

        // Two simultaneous requests: 0 then 2, back to back
        do_reset();
        req = 4'b0101;
        step();
        expect_packet(0, body[0], 1'b1);
        step();
        expect_packet(2, body[2], 1'b1);
        check("two_count", 32'(tx_count), 32'd2);
        step();
        check("two_idle", {23'd0, datak_out, data_out}, 32'h000);

        // Fairness: all held, order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        step();
        for (int p = 0; p < 5; p++) begin
            expect_packet(p % N_REQ, body[p % N_REQ], 1'b0);
            step();
        end
        check("fair_count", 32'(tx_count), 32'd5);
        check("fair_next_grant", 32'(grant), 32'b0010);
        req = '0;

        // GAP=2 instance: two idle symbols between FD and next FB
        do_reset();
        req = 4'b1111;
        step();
        check("gap_stp0", {27'd0, g_grant, g_datak}, {27'd0, 4'b0001, 1'b1});
        for (int i = 0; i < 19; i++) step();
        check("gap_end", {23'd0, g_datak, g_data}, 32'h1FD);
        step();
        check("gap_idle1", {23'd0, g_datak, g_data}, 32'h000);
        step();
        check("gap_idle2", {23'd0, g_datak, g_data}, 32'h000);
        step();
        check("gap_stp1", {23'd0, g_datak, g_data}, 32'h1FB);
        check("gap_grant1", 32'(g_grant), 32'b0010);
        req = '0;

        // Enable low: no grant
        do_reset();
        en  = 1'b0;
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            step();
            check("en0_lane", {27'd0, grant, datak_out, busy, data_out[1:0]}, 32'd0);
            check("en0_data", 32'(data_out), 32'h00);
        end
        // Enable dropped during BODY: packet completes, nothing follows
        en = 1'b1;
        step();
        check("en1_grant", 32'(grant), 32'b0010);
        check("en1_stp", {23'd0, datak_out, data_out}, 32'h1FB);
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 3) en = 1'b0;
            check($sformatf("en_body_b%0d", i), {23'd0, datak_out, data_out}, {24'd0, body[1][8*i +: 8]});
        end
        step();
        check("en_end", {23'd0, datak_out, data_out}, 32'h1FD);
        check("en_count", 32'(tx_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_after", {22'd0, busy, datak_out, data_out}, 32'h000);
        end
        en  = 1'b1;
        req = '0;

        // Reset in BODY count 5, then req[3] alone is granted
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        for (int i = 0; i < 6; i++) step();
        check("mid_byte5", 32'(data_out), 32'(body[0][47:40]));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_lane", {22'd0, busy, datak_out, data_out}, 32'h000);
        check("mid_rst_count", 32'(tx_count), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("mid_no_end", {23'd0, datak_out, data_out}, 32'h000);
        end
        req = 4'b1000;
        step();
        expect_packet(3, body[3], 1'b1);
        check("mid_count", 32'(tx_count), 32'd1);

        // Wrap: 17 packets, tx_count 0 after 16, 1 after 17
        do_reset();
        req = 4'b0001;
        step();
        for (int p = 0; p < 17; p++) begin
            check("wrap_stp", {23'd0, datak_out, data_out}, 32'h1FB);
            if (p == 16) req = '0;
            for (int i = 0; i < 19; i++) step();
            if (p == 15) check("wrap_16", 32'(tx_count), 32'd0);
            if (p < 16) step();
        end
        check("wrap_end", {23'd0, datak_out, data_out}, 32'h1FD);
        check("wrap_17", 32'(tx_count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tlp_tx_scheduler.md
# tlp_tx_scheduler

Round-robin transmit scheduler that shares the single framed byte lane (`data`/`datak`) between several TLP sources. It grants one requester at a time and serializes that requester's 18-byte body between an STP symbol (8'hFB, K) and an END symbol (8'hFD, K). The result is a 20-symbol TLP, the exact framing the link-side TLP detector accepts. It sits upstream of the detector, on the transmit side of the link, and is the only driver of that lane.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `GAP`, default 0: idle symbols inserted after END before the next STP (0..15).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the next rising edge.
- `en` in 1: when 0, no new grant is issued; a packet in flight always completes.
- `req` in N_REQ: per-requester request level; held high with body stable until granted.
- `req_body` in N_REQ*144: flattened bodies; requester i at [i*144 +: 144]; byte 0 at bits [7:0].
- `grant` out N_REQ: one-hot, single-cycle pulse in the cycle STP is driven.
- `data_out` out 8: lane byte.
- `datak_out` out 1: 1 = control symbol (STP/END), 0 = data/idle.
- `busy` out 1: high from the STP cycle through the END cycle inclusive.
- `tx_count` out 4: TLPs sent, mod 16.

## Operation
- States: IDLE, STP, BODY, END, GAP.
- IDLE:
  - Drives 8'h00 with datak 0.
  - If `en` is high and any `req` is high, the arbiter selects a winner. On the same edge, its body is latched into a 144-bit shift register, the winner index is saved, and the state moves to STP.
- STP: drives 8'hFB with datak 1 and `grant[winner]` = 1; then moves to BODY.
- BODY:
  - 18 cycles, driving latched bytes 0..17 in order with datak 0.
  - A 5-bit counter runs 0..17; at 17 the state moves to END.
- END:
  - Drives 8'hFD with datak 1; `tx_count` increments (wraps 15→0).
  - If `GAP` = 0, the state acts as IDLE for arbitration: with `en` and a request present it goes to STP, otherwise to IDLE.
  - If `GAP` > 0, it goes to GAP.
- GAP:
  - Drives 8'h00 with datak 0 for `GAP` cycles.
  - Arbitration happens on the last GAP cycle, with the same rule as END at `GAP` = 0.
- Arbitration is round-robin:
  - Search starts at `last+1` (mod N_REQ); the first high `req` wins.
  - `last` updates to the winner when the grant is taken.
  - Reset value of `last` is N_REQ-1, so requester 0 has first priority.
- The body is sampled only at the arbitration edge; later changes to `req_body` do not affect the packet in flight.
- The requester may drop `req` on the edge after `grant`. If it holds `req` high, that is a new request for its next packet.
- A `req` that drops before being granted is simply not served; there is no error.
- The body type byte (byte 2, bits [23:16]) is passed through unmodified; TLP type decode is not this block's job.

## Timing
- All outputs are registered.
- Reset values: `data_out` = 8'h00, `datak_out` = 0, `grant` = 0, `busy` = 0, `tx_count` = 0, state = IDLE, `last` = N_REQ-1.
- Latency: `req` sampled high in IDLE at edge t gives STP in cycle t+1, body in t+2..t+19, and END in t+20.
- Throughput: with `GAP` = 0 and continuous requests, back-to-back packets run at 20 cycles per TLP (END immediately followed by STP).
- `en` low while a packet is in flight has no effect on that packet; it only blocks the next arbitration.
- Reset asserted mid-packet aborts it: next cycle the lane shows 8'h00/0, no END is sent, `tx_count` = 0, and the latched body is discarded.
- Simultaneous requests are resolved by the round-robin pointer only; no requester is granted twice while another is waiting.

## Structure
- Package `tlp_pkg`:
  - Constants: `K_STP` = 8'hFB, `K_END` = 8'hFD, `IDLE_BYTE` = 8'h00, `TLP_BODY_BYTES` = 18.
  - `tx_state_t` enum covering IDLE/STP/BODY/END/GAP.
- Sub-module `rr_arbiter` (parameter N_REQ):
  - Combinational winner and valid from `req` and `last`.
  - Pointer register updated on an `accept` strobe.
  - Reusable elsewhere in the link logic.

## Test plan
- Single request: req[0] with body bytes 0x01..0x12. Lane must read FB(K), 01..12, FD(K); `grant[0]` high only in the FB cycle; `tx_count` = 1; `busy` high for exactly 20 cycles.
- Two requests: req[0] and req[2] raised together and held until granted. Grants go to 0 then 2; the second FB immediately follows the first FD; `tx_count` = 2.
- Fairness: all four requests held continuously for 5 packets. Grant order must be 0, 1, 2, 3, 0.
- Gap: `GAP` = 2 with back-to-back requests. Exactly two 00/0 symbols appear between FD and the next FB.
- Enable control:
  - `en` = 0 with req[1] high: no grant, lane stays idle.
  - `en` dropped during BODY: the current packet still ends with FD, and no further STP follows.
- Reset mid-packet: reset asserted in BODY count 5. Next cycle the lane is 00/0 and `tx_count` = 0; a subsequent req[3] alone is granted normally.
- Wrap: 17 packets sent. `tx_count` must end at 1.
